// File: rtl/ifetch_queue.sv
// Prefetching fetch stage: ack-to-v_o latency 1 cycle (no bypass), up to MAXOUT requests in flight.
// Backpressure: rdy_i low holds the head; requests stop once queue slots plus in-flight reach DEPTH.

module ifq_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head_dat,
    output logic [CW-1:0] o_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    // Storage is data-only; occupancy is tracked by the pointers and r_cnt.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head_dat = r_mem[r_rd];
    assign o_cnt      = r_cnt;
endmodule

module ifetch_queue #(
    parameter int          WORD   = 32,
    parameter int          ADDR   = 16,
    parameter int          DEPTH  = 4,
    parameter int          MAXOUT = 2,
    parameter int unsigned RST_PC = 0,
    parameter int unsigned INC    = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_o,
    output logic [ADDR-1:0] addr_o,
    input  logic            gnt_i,
    input  logic            ack_i,
    input  logic [WORD-1:0] inst_i,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    input  logic            rdy_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] baddr_i,
    output logic            err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAXOUT + 1);

    typedef struct packed {
        logic [ADDR-1:0] pc;
        logic [WORD-1:0] inst;
    } ent_t;

    logic [ADDR-1:0] r_fetch_pc;
    logic [ADDR-1:0] r_resp_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop;
    logic            r_err;

    logic [CW-1:0]   w_cnt;
    ent_t            w_head;
    ent_t            w_push_ent;
    logic            w_credit_q;
    logic            w_credit_o;
    logic            w_req;
    logic            w_fire;
    logic            w_ack_drop;
    logic            w_ack_push;
    logic            w_ack_spur;
    logic            w_push;
    logic            w_pop;
    logic [OW-1:0]   w_drop_sum;

    // Queue credit counts in-flight requests too, so every live ack has a slot waiting.
    assign w_credit_q = (int'(w_cnt) + int'(r_outst)) < DEPTH;
    assign w_credit_o = (int'(r_outst) + int'(r_drop)) < MAXOUT;
    assign w_req      = rst & ~branch_i & w_credit_q & w_credit_o;
    assign w_fire     = w_req & gnt_i;

    assign w_ack_drop = ack_i & (r_drop != '0);
    assign w_ack_push = ack_i & (r_drop == '0) & (r_outst != '0);
    assign w_ack_spur = ack_i & (r_drop == '0) & (r_outst == '0);

    assign w_push     = w_ack_push & ~branch_i;
    assign w_pop      = v_o & rdy_i & ~branch_i;
    assign w_drop_sum = r_drop + r_outst;

    assign w_push_ent.pc   = r_resp_pc;
    assign w_push_ent.inst = inst_i;

    ifq_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (branch_i),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_cnt      (w_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= ADDR'(RST_PC);
            r_resp_pc  <= ADDR'(RST_PC);
            r_outst    <= '0;
            r_drop     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_ack_spur) begin
                r_err <= 1'b1;
            end
            if (branch_i) begin
                // Everything in flight becomes stale; an ack arriving now retires one of them.
                r_fetch_pc <= baddr_i;
                r_resp_pc  <= baddr_i;
                r_outst    <= '0;
                r_drop     <= w_drop_sum - OW'(ack_i && (w_drop_sum != '0));
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR'(INC);
                end
                if (w_ack_push) begin
                    r_resp_pc <= r_resp_pc + ADDR'(INC);
                end
                r_outst <= r_outst + OW'(w_fire) - OW'(w_ack_push);
                r_drop  <= r_drop - OW'(w_ack_drop);
            end
        end
    end

    assign req_o  = w_req;
    assign addr_o = r_fetch_pc;
    assign v_o    = (w_cnt != '0);
    assign inst_o = w_head.inst;
    assign pc_o   = w_head.pc;
    assign err_o  = r_err;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: vector table, directed corner sequences and randomized traffic
// checked against a queue-based model of fetched words and in-flight requests.

module tb_ifetch_queue;
    localparam int DEPTH  = 4;
    localparam int MAXOUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_o;
    logic [15:0] addr_o;
    logic        gnt_i = 1'b0;
    logic        ack_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic        v_o;
    logic [31:0] inst_o;
    logic [15:0] pc_o;
    logic        rdy_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [15:0] baddr_i = '0;
    logic        err_o;

    always #5 clk = ~clk;

    ifetch_queue #(
        .WORD(32), .ADDR(16), .DEPTH(DEPTH), .MAXOUT(MAXOUT), .RST_PC(0), .INC(1)
    ) dut (
        .clk(clk), .rst(rst), .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
        .ack_i(ack_i), .inst_i(inst_i), .v_o(v_o), .inst_o(inst_o), .pc_o(pc_o),
        .rdy_i(rdy_i), .branch_i(branch_i), .baddr_i(baddr_i), .err_o(err_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: fetched words awaiting decode, and requests the memory still owes.
    typedef struct { logic [15:0] addr; bit stale; int cyc; } fl_t;
    typedef struct { logic [15:0] pc; logic [31:0] inst; } ent_t;
    fl_t         flight[$];
    ent_t        fifo_q[$];
    logic [15:0] m_pc;
    bit          m_err;
    int          cyc;
    int          obs_fl;
    bit          e_req, e_v;
    bit          c_g, c_a, c_r, c_b;
    logic [15:0] c_ba;

    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a ^ 16'hBEEF, ~a};
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (flight[i]) if (!flight[i].stale) n++;
        return n;
    endfunction

    task automatic drive(input bit g, input bit a, input bit r, input bit b, input logic [15:0] ba);
        c_g = g; c_a = a; c_r = r; c_b = b; c_ba = ba;
        gnt_i = g; ack_i = a; rdy_i = r; branch_i = b; baddr_i = ba;
        inst_i = 32'hBAD0_0000;
        if (a && flight.size() > 0) inst_i = mem(flight[0].addr);
        #1;
        e_req = !b && (fifo_q.size() + live_cnt() < DEPTH) && (flight.size() < MAXOUT);
        e_v   = fifo_q.size() != 0;
        chk("req_o", req_o, e_req);
        if (e_req) chk("addr_o", addr_o, m_pc);
        chk("v_o", v_o, e_v);
        if (e_v) begin
            chk("pc_o", pc_o, fifo_q[0].pc);
            chk("inst_o", inst_o, fifo_q[0].inst);
        end
        chk("err_o", err_o, m_err);
    endtask

    task automatic advance();
        fl_t h;
        if (c_a && obs_fl > 0) obs_fl--;
        if (req_o && c_g) obs_fl++;
        chk("inflight_le_maxout", obs_fl <= MAXOUT, 1);
        if (c_b) begin
            if (c_a) begin
                if (flight.size() > 0) void'(flight.pop_front());
                else m_err = 1'b1;
            end
            foreach (flight[i]) flight[i].stale = 1'b1;
            fifo_q.delete();
            m_pc = c_ba;
        end else begin
            if (e_v && c_r) void'(fifo_q.pop_front());
            if (c_a) begin
                if (flight.size() == 0) m_err = 1'b1;
                else begin
                    h = flight.pop_front();
                    if (!h.stale) fifo_q.push_back('{h.addr, mem(h.addr)});
                end
            end
            if (e_req && c_g) begin
                flight.push_back('{m_pc, 1'b0, cyc});
                m_pc = m_pc + 16'd1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        gnt_i = 0; ack_i = 0; rdy_i = 0; branch_i = 0; baddr_i = '0; inst_i = '0;
        flight.delete(); fifo_q.delete();
        m_pc = 16'h0; m_err = 0; obs_fl = 0;
        #2;
        chk("rst_req_o", req_o, 0);
        chk("rst_v_o", v_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_addr_o", addr_o, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit rs; bit g; bit a; bit r; bit b; logic [15:0] ba;
        bit e_req; logic [15:0] e_addr; bit e_v; logic [15:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input bit rs, input bit g, input bit a, input bit r,
                                input bit er, input logic [15:0] ea, input bit ev,
                                input logic [15:0] ep);
        vec_t v;
        v.rs = rs; v.g = g; v.a = a; v.r = r; v.b = 1'b0; v.ba = '0;
        v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep;
        return v;
    endfunction

    initial begin
        vec_t tbl [16];
        int   lat;
        bit   g, a, r, b;
        logic [15:0] ba;

        // Streaming with 1-cycle acks, then a full-stall from reset with later release.
        tbl[0]  = mk(1, 1, 0, 1, 1, 16'd0, 0, 16'd0);
        tbl[1]  = mk(0, 1, 1, 1, 1, 16'd1, 0, 16'd0);
        tbl[2]  = mk(0, 1, 1, 1, 1, 16'd2, 1, 16'd0);
        tbl[3]  = mk(0, 1, 1, 1, 1, 16'd3, 1, 16'd1);
        tbl[4]  = mk(0, 1, 1, 1, 1, 16'd4, 1, 16'd2);
        tbl[5]  = mk(1, 1, 0, 0, 1, 16'd0, 0, 16'd0);
        tbl[6]  = mk(0, 1, 1, 0, 1, 16'd1, 0, 16'd0);
        tbl[7]  = mk(0, 1, 1, 0, 1, 16'd2, 1, 16'd0);
        tbl[8]  = mk(0, 1, 1, 0, 1, 16'd3, 1, 16'd0);
        tbl[9]  = mk(0, 1, 1, 0, 0, 16'd0, 1, 16'd0);
        tbl[10] = mk(0, 1, 0, 0, 0, 16'd0, 1, 16'd0);
        tbl[11] = mk(0, 1, 0, 1, 0, 16'd0, 1, 16'd0);
        tbl[12] = mk(0, 1, 0, 1, 1, 16'd4, 1, 16'd1);
        tbl[13] = mk(0, 1, 1, 1, 1, 16'd5, 1, 16'd2);
        tbl[14] = mk(0, 1, 1, 1, 1, 16'd6, 1, 16'd3);
        tbl[15] = mk(0, 1, 0, 1, 1, 16'd7, 1, 16'd4);

        #3;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rs) do_reset();
            drive(tbl[i].g, tbl[i].a, tbl[i].r, tbl[i].b, tbl[i].ba);
            chk($sformatf("tbl%0d_req", i), req_o, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), addr_o, tbl[i].e_addr);
            chk($sformatf("tbl%0d_v", i), v_o, tbl[i].e_v);
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), inst_o, mem(tbl[i].e_pc));
            end
            advance();
        end

        // Branch with two requests (5,6) in flight.
        do_reset();
        drive(0, 0, 0, 1, 16'h5);  advance();
        drive(1, 0, 0, 0, 16'h0);  chk("t4_addr5", addr_o, 16'h5); advance();
        drive(1, 0, 0, 0, 16'h0);  chk("t4_addr6", addr_o, 16'h6); advance();
        drive(1, 0, 0, 1, 16'h40); chk("t4_no_req_in_branch", req_o, 0); advance();
        drive(1, 1, 1, 0, 16'h0);  chk("t4_v_flushed", v_o, 0); advance();
        drive(1, 1, 1, 0, 16'h0);  chk("t4_req_0x40", req_o && addr_o == 16'h40, 1); advance();
        drive(1, 1, 0, 0, 16'h0);  chk("t4_stale_not_delivered", v_o, 0); advance();
        drive(0, 0, 0, 0, 16'h0);
        chk("t4_pc_0x40", pc_o, 16'h40);
        chk("t4_inst_0x40", inst_o, mem(16'h40));
        advance();

        // Branch coinciding with an ack, then a second branch one cycle later.
        do_reset();
        drive(1, 0, 0, 0, 16'h0);  advance();
        drive(1, 0, 0, 0, 16'h0);  advance();
        drive(1, 1, 0, 1, 16'h20); advance();
        drive(1, 0, 0, 1, 16'h30); chk("t5_no_req_in_branch", req_o, 0); advance();
        drive(1, 1, 0, 0, 16'h0);  chk("t5_req_0x30", req_o && addr_o == 16'h30, 1); advance();
        drive(0, 1, 0, 0, 16'h0);  chk("t5_empty_before_ack", v_o, 0); advance();
        drive(0, 0, 1, 0, 16'h0);
        chk("t5_pc_0x30", pc_o, 16'h30);
        chk("t5_err_clear", err_o, 0);
        advance();
        drive(0, 0, 1, 0, 16'h0);  chk("t5_only_target", v_o, 0); advance();

        // Spurious acks, reset clearing err, wrap of the fetch address.
        do_reset();
        drive(0, 1, 0, 0, 16'h0);  advance();
        drive(0, 0, 0, 0, 16'h0);  chk("t6_err_set", err_o, 1); chk("t6_v_still_0", v_o, 0); advance();
        drive(1, 0, 0, 0, 16'h0);  advance();
        drive(0, 1, 0, 0, 16'h0);  advance();
        drive(0, 1, 0, 0, 16'h0);  chk("t6_head_pc0", pc_o, 16'h0); advance();
        drive(0, 0, 1, 0, 16'h0);  chk("t6_one_entry", v_o, 1); advance();
        drive(0, 0, 1, 0, 16'h0);  chk("t6_cnt_unchanged", v_o, 0); advance();
        drive(1, 0, 0, 0, 16'h0);  advance();
        do_reset();
        chk("t6_err_cleared", err_o, 0);
        drive(0, 1, 0, 0, 16'h0);  advance();
        drive(0, 0, 0, 0, 16'h0);  chk("t6_err_after_reset_ack", err_o, 1); advance();
        do_reset();
        drive(0, 0, 0, 1, 16'hFFFF); advance();
        drive(1, 0, 0, 0, 16'h0);  chk("t6_addr_ffff", addr_o, 16'hFFFF); advance();
        drive(1, 0, 0, 0, 16'h0);  chk("t6_wrap", addr_o, 16'h0000); advance();

        // Long fixed ack latency: the in-flight bound is checked every cycle.
        do_reset();
        lat = 3;
        for (int i = 0; i < 200; i++) begin
            a = 1'b0;
            if (flight.size() > 0) a = (cyc - flight[0].cyc) >= lat;
            drive(1, a, 1, 0, 16'h0);
            advance();
        end

        // Randomized traffic with branches and occasional spurious acks.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            g  = $urandom_range(0, 3) != 0;
            r  = $urandom_range(0, 2) != 0;
            b  = $urandom_range(0, 24) == 0;
            ba = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            lat = $urandom_range(1, 3);
            a  = 1'b0;
            if (flight.size() > 0) a = ((cyc - flight[0].cyc) >= lat) && ($urandom_range(0, 2) != 0);
            else a = $urandom_range(0, 199) == 0;
            drive(g, a, r, b, ba);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
